// File: rtl/object_spawner.sv
// object_spawner -- spawn scheduler and score/combo arbiter for the catch game.
//
// Every `period` frame ticks the scheduler picks the lowest-index free slot. It
// then fires a one-cycle object_on pulse to that slot, with an LFSR-derived x
// centre and object code.
//
// Per-slot catch events are held pending and drained one per cycle,
// round-robin, into a single registered score stream. Per-slot miss events are
// ORed into a registered combo_clear pulse.
//
// Optional build macro: SPAWN_SPEEDUP_EN. When it is defined, every 8th spawn
// shortens the spawn period by one frame, down to MIN_PERIOD. When it is left
// undefined, the period is fixed at SPAWN_PERIOD.
//
// Ports:
//   Clk              system clock (50 MHz)
//   Reset            synchronous, active-high reset
//   frame_clk        ~60 Hz frame strobe (asynchronous level)
//   game_active      spawning enabled while high
//   slot_idle[i]     slot i free to take a new object
//   hit[i]           catch pulse from slot i
//   hit_pts[4i+:4]   points value of slot i
//   miss[i]          combo-break pulse from slot i
//   object_on        one-hot, one-cycle spawn pulse
//   object_position  x centre of the spawned object (48..559)
//   obj_code         type of the spawned object
//   score_valid      one-cycle score event
//   score_pts        points carried by the score event
//   combo_clear      one-cycle combo-clear pulse

// One pending-catch bit per slot. A hit landing in the same cycle as this
// slot's grant wins, so the new catch is not lost.
module object_spawner_pend (
  input  logic Clk,
  input  logic Reset,
  input  logic hit,
  input  logic grant,
  output logic pending
);
  always_ff @(posedge Clk) begin
    if (Reset) pending <= 1'b0;
    else       pending <= (pending & ~grant) | hit;
  end
endmodule

module object_spawner #(
  parameter int          N_SLOTS      = 4,
  parameter logic [9:0]  SPAWN_PERIOD = 10'd90,
  parameter logic [9:0]  MIN_PERIOD   = 10'd30,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 game_active,
  input  logic [N_SLOTS-1:0]   slot_idle,
  input  logic [N_SLOTS-1:0]   hit,
  input  logic [4*N_SLOTS-1:0] hit_pts,
  input  logic [N_SLOTS-1:0]   miss,
  output logic [N_SLOTS-1:0]   object_on,
  output logic [9:0]           object_position,
  output logic [1:0]           obj_code,
  output logic                 score_valid,
  output logic [3:0]           score_pts,
  output logic                 combo_clear
);
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, PICK, FIRE} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [1:0] code;
  } spawn_t;

  state_t        state;
  logic [9:0]    frame_cnt;
  logic [9:0]    period;
  logic [SW-1:0] sel;
  spawn_t        spawn;
  logic [15:0]   lfsr;
  logic          frame_clk_delayed;
  logic          frame_tick;

  // frame edge detect
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_delayed <= 1'b0;
      frame_tick        <= 1'b0;
    end else begin
      frame_clk_delayed <= frame_clk;
      frame_tick        <= frame_clk & ~frame_clk_delayed;
    end
  end

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, free-running
  always_ff @(posedge Clk) begin
    if (Reset) lfsr <= SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // lowest-index free slot
  logic          free_any;
  logic [SW-1:0] free_sel;
  always_comb begin
    free_any = 1'b0;
    free_sel = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (slot_idle[i]) begin
        free_any = 1'b1;
        free_sel = SW'(i);
      end
    end
  end

`ifdef SPAWN_SPEEDUP_EN
  logic [2:0] spawn_cnt;
  // The reload in the FIRE cycle still sees the old period, so a shortened
  // period first takes effect at the following reload.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      period    <= SPAWN_PERIOD;
      spawn_cnt <= 3'd0;
    end else if (state == FIRE) begin
      spawn_cnt <= spawn_cnt + 3'd1;
      if (spawn_cnt == 3'd7 && period > MIN_PERIOD) period <= period - 10'd1;
    end
  end
`else
  assign period = SPAWN_PERIOD;
  // MIN_PERIOD only matters when the speed-up build is selected.
  logic unused_min_period;
  assign unused_min_period = ^MIN_PERIOD;
`endif

  // spawn FSM
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      frame_cnt <= SPAWN_PERIOD;
      sel       <= '0;
      object_on <= '0;
      spawn     <= '{x: 10'd320, code: 2'b00};
    end else begin
      object_on <= '0;
      unique case (state)
        IDLE: begin
          frame_cnt <= period;
          if (game_active) state <= WAIT;
        end
        WAIT: begin
          if (!game_active)        state     <= IDLE;
          else if (frame_cnt == 0) state     <= PICK;
          else if (frame_tick)     frame_cnt <= frame_cnt - 10'd1;
        end
        // Waits here while every slot is busy. Nothing is queued, so the
        // spawn fires exactly once when a slot frees up.
        PICK: begin
          if (!game_active) state <= IDLE;
          else if (free_any) begin
            sel        <= free_sel;
            spawn.x    <= {1'b0, lfsr[8:0]} + 10'd48;
            spawn.code <= lfsr[11:10];
            state      <= FIRE;
          end
        end
        FIRE: begin
          object_on <= N_SLOTS'(1) << sel;
          frame_cnt <= period;
          state     <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign object_position = spawn.x;
  assign obj_code        = spawn.code;

  // score arbiter
  logic [N_SLOTS-1:0] pending;
  logic [N_SLOTS-1:0] gnt;
  logic               gnt_any;
  logic [SW-1:0]      gnt_idx;
  logic [SW-1:0]      rr_ptr;

  object_spawner_pend u_pend [N_SLOTS-1:0] (
    .Clk     (Clk),
    .Reset   (Reset),
    .hit     (hit),
    .grant   (gnt),
    .pending (pending)
  );

  // first pending slot at or after rr_ptr, wrapping
  always_comb begin : p_arb
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_SLOTS) idx = idx - N_SLOTS;
      if (!gnt_any && pending[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
    gnt = gnt_any ? (N_SLOTS'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      score_valid <= 1'b0;
      score_pts   <= 4'd0;
      rr_ptr      <= '0;
      combo_clear <= 1'b0;
    end else begin
      score_valid <= gnt_any;
      combo_clear <= |miss;
      if (gnt_any) begin
        score_pts <= hit_pts[{gnt_idx, 2'b00} +: 4];
        rr_ptr    <= (gnt_idx == SW'(N_SLOTS - 1)) ? '0 : gnt_idx + SW'(1);
      end
    end
  end
endmodule

// File: tb/tb_object_spawner.sv
module tb_object_spawner;
  localparam int          N    = 4;
  localparam logic [9:0]  SP   = 10'd3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           frame_clk = 1'b0;
  logic           game_active = 1'b0;
  logic [N-1:0]   slot_idle = 4'b1111;
  logic [N-1:0]   hit = '0;
  logic [4*N-1:0] hit_pts = '0;
  logic [N-1:0]   miss = '0;
  logic [N-1:0]   object_on;
  logic [9:0]     object_position;
  logic [1:0]     obj_code;
  logic           score_valid;
  logic [3:0]     score_pts;
  logic           combo_clear;

  object_spawner #(.N_SLOTS(N), .SPAWN_PERIOD(SP), .MIN_PERIOD(10'd1), .SEED(SEED)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_active(game_active),
    .slot_idle(slot_idle), .hit(hit), .hit_pts(hit_pts), .miss(miss),
    .object_on(object_on), .object_position(object_position), .obj_code(obj_code),
    .score_valid(score_valid), .score_pts(score_pts), .combo_clear(combo_clear)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tick_cnt = 0;
  int n_spawn  = 0;
  int spawn_tick = 0;

  logic [N-1:0] exp_on_q[$];
  logic [3:0]   exp_pts_q[$];
  int           exp_combo_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // frame strobe: rises at phase 0 of every 20-cycle frame, 5 cycles high
  initial begin
    forever begin
      @(posedge Clk); #1;
      if (cyc % 20 == 0) begin frame_clk = 1'b1; tick_cnt++; end
      else if (cyc % 20 == 5) frame_clk = 1'b0;
    end
  end

  // reference LFSR with two cycles of history (value seen in the last PICK cycle)
  logic [15:0] m_lfsr, h1, h2;
  always @(posedge Clk) begin
    if (Reset) m_lfsr <= SEED;
    else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    h1 <= m_lfsr;
    h2 <= h1;
  end

  // monitor: pops expected responses whenever the DUT presents an output
  always @(negedge Clk) begin
    if (!Reset) begin
      if (object_on != '0) begin
        logic [9:0] ex;
        n_spawn++;
        spawn_tick = tick_cnt;
        if (exp_on_q.size() == 0) chk("unexpected_spawn", 32'(object_on), 32'd0);
        else chk("spawn_slot", 32'(object_on), 32'(exp_on_q.pop_front()));
        ex = {1'b0, h2[8:0]} + 10'd48;
        chk("spawn_x", 32'(object_position), 32'(ex));
        chk("spawn_code", 32'(obj_code), 32'(h2[11:10]));
        chk("spawn_x_range", 32'(object_position >= 10'd48 && object_position <= 10'd559), 32'd1);
      end
      if (score_valid) begin
        if (exp_pts_q.size() == 0) chk("unexpected_score", 32'(score_valid), 32'd0);
        else chk("score_pts", 32'(score_pts), 32'(exp_pts_q.pop_front()));
      end
      if (combo_clear) begin
        if (exp_combo_q.size() == 0) chk("unexpected_combo", 32'(combo_clear), 32'd0);
        else chk("combo_clear", 32'(combo_clear), 32'(exp_combo_q.pop_front()));
      end
    end
  end

  task automatic wait_spawns(input int target, input string nm);
    int k = 0;
    while (n_spawn < target && k < 400) begin @(posedge Clk); k++; end
    chk(nm, 32'(n_spawn), 32'(target));
  endtask

  task automatic raise_game(output int t0);
    do @(posedge Clk); while (cyc % 20 != 10);
    #1 game_active = 1'b1;
    t0 = tick_cnt;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge Clk);
  endtask

  initial begin
    int t0, prev, ns;
    // reset state
    wait_cycles(3);
    @(negedge Clk);
    chk("rst_object_on", 32'(object_on), 32'd0);
    chk("rst_position", 32'(object_position), 32'd320);
    chk("rst_code", 32'(obj_code), 32'd0);
    chk("rst_score_valid", 32'(score_valid), 32'd0);
    chk("rst_score_pts", 32'(score_pts), 32'd0);
    chk("rst_combo", 32'(combo_clear), 32'd0);
    @(posedge Clk); #1 Reset = 1'b0;

    // two spawns into slot 0, then slot 0 busy -> slot 1
    exp_on_q.push_back(4'b0001);
    exp_on_q.push_back(4'b0001);
    raise_game(t0);
    wait_spawns(1, "spawn1_seen");
    chk("spawn1_ticks", 32'(spawn_tick - t0), 32'd3);
    prev = spawn_tick;
    wait_spawns(2, "spawn2_seen");
    chk("spawn2_ticks", 32'(spawn_tick - prev), 32'd3);
    prev = spawn_tick;
    slot_idle = 4'b1110;
    exp_on_q.push_back(4'b0010);
    wait_spawns(3, "spawn3_seen");
    chk("spawn3_ticks", 32'(spawn_tick - prev), 32'd3);

    // all slots busy: stall in PICK, release slot 2
    slot_idle = 4'b0000;
    wait_cycles(130);
    chk("stall_no_spawn", 32'(n_spawn), 32'd3);
    exp_on_q.push_back(4'b0100);
    @(posedge Clk); #1 slot_idle = 4'b0100;
    @(posedge Clk); #1 chk("release_plus1", 32'(object_on), 32'd0);
    @(posedge Clk); #1 chk("release_plus2", 32'(object_on), 32'b0100);
    slot_idle = 4'b0000;
    @(posedge Clk); #1 chk("release_plus3", 32'(object_on), 32'd0);

    // drop game_active while in WAIT
    game_active = 1'b0;
    slot_idle = 4'b1111;

    // score arbiter: all four hit at once, slot 1 re-hit during its grant
    hit_pts = {4'd0, 4'd1, 4'd2, 4'd3};
    exp_pts_q.push_back(4'd3);
    exp_pts_q.push_back(4'd2);
    exp_pts_q.push_back(4'd1);
    exp_pts_q.push_back(4'd0);
    exp_pts_q.push_back(4'd2);
    @(posedge Clk); #1 hit = 4'b1111;
    @(posedge Clk); #1 hit = 4'b0000;
    @(posedge Clk); #1 hit = 4'b0010;
    @(posedge Clk); #1 hit = 4'b0000;
    wait_cycles(10);
    chk("score_q_drained", 32'(exp_pts_q.size()), 32'd0);

    // combo clear from misses in consecutive cycles
    exp_combo_q.push_back(1);
    exp_combo_q.push_back(1);
    @(posedge Clk); #1 miss = 4'b0001;
    @(posedge Clk); #1 miss = 4'b1000;
    @(posedge Clk); #1 miss = 4'b0000;
    wait_cycles(4);
    chk("combo_q_drained", 32'(exp_combo_q.size()), 32'd0);

    wait_cycles(100);
    chk("idle_after_wait_drop", 32'(n_spawn), 32'd4);
    exp_on_q.push_back(4'b0001);
    raise_game(t0);
    wait_spawns(5, "spawn5_seen");
    chk("spawn5_full_period", 32'(spawn_tick - t0), 32'd3);

    // drop game_active while stalled in PICK
    slot_idle = 4'b0000;
    wait_cycles(100);
    game_active = 1'b0;
    wait_cycles(2);
    slot_idle = 4'b1111;
    wait_cycles(60);
    chk("idle_after_pick_drop", 32'(n_spawn), 32'd5);
    exp_on_q.push_back(4'b0001);
    raise_game(t0);
    ns = n_spawn;
    wait_spawns(ns + 1, "spawn6_seen");
    chk("spawn6_full_period", 32'(spawn_tick - t0), 32'd3);
    #1 game_active = 1'b0;
    wait_cycles(10);
    chk("spawn_q_drained", 32'(exp_on_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
